// File: rtl/sysid_uptime_slave.sv
// sysid_uptime_slave
// Avalon-MM system identification slave: fixed ID and build timestamp words,
// a prescaled free-running uptime counter with an atomic two-word read,
// two scratch registers, a control word and a capability word.
// Read latency is fixed at one cycle and there is no waitrequest.

module sysid_uptime_slave #(
  parameter logic [31:0] ID_VALUE  = 32'd0,
  parameter logic [31:0] TIMESTAMP = 32'd1671639825,
  parameter int unsigned CNT_WIDTH = 48,    // 33..64
  parameter int unsigned PRESCALE  = 1      // 1..65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  // Word map of the slave.
  typedef enum logic [2:0] {
    REG_ID       = 3'd0,
    REG_TSTAMP   = 3'd1,
    REG_UP_LO    = 3'd2,
    REG_UP_HI    = 3'd3,
    REG_SCRATCH0 = 3'd4,
    REG_SCRATCH1 = 3'd5,
    REG_CTRL     = 3'd6,
    REG_CAPS     = 3'd7
  } reg_e;

  localparam int unsigned          HI_W    = CNT_WIDTH - 32;
  localparam logic [15:0]          PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [31:0]          CAPS    = {16'd0, 8'(PRESCALE - 1), 8'(CNT_WIDTH)};

  logic [CNT_WIDTH-1:0] cnt;
  logic [15:0]          presc;
  logic [31:0]          shadow;
  logic [31:0]          scratch0;
  logic [31:0]          scratch1;
  logic                 en;

  logic                 ctrl_wr;
  logic                 clr;
  logic                 tick;
  logic [31:0]          cnt_hi;
  logic [31:0]          rd_mux;

  // Control decode: CTRL is only written when its low byte lane is enabled.
  assign ctrl_wr = write && (address == REG_CTRL) && byteenable[0];
  assign clr     = ctrl_wr && writedata[1];
  assign tick    = en && (presc == PRE_MAX);

  // Upper counter bits, zero-extended to a full word for the shadow register.
  always_comb begin
    // NOTE: default first so every path assigns cnt_hi and no latch is inferred.
    cnt_hi = '0;
    cnt_hi[HI_W-1:0] = cnt[CNT_WIDTH-1:32];
  end

  // Prescaler and uptime counter; a clear request overrides a coincident tick.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      cnt   <= '0;
      presc <= '0;
    end else if (clr) begin
      cnt   <= '0;
      presc <= '0;
    end else if (en) begin
      if (tick) begin
        cnt   <= cnt + CNT_ONE;
        presc <= '0;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  // Scratch registers with per-byte write enables, plus the EN control bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch0 <= '0;
      scratch1 <= '0;
      en       <= 1'b1;
    end else begin
      if (write && (address == REG_SCRATCH0)) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch0[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (write && (address == REG_SCRATCH1)) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch1[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (ctrl_wr) en <= writedata[0];
    end
  end

  // Read multiplexer over the current (pre-write) register values.
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_ID:       rd_mux = ID_VALUE;
      REG_TSTAMP:   rd_mux = TIMESTAMP;
      REG_UP_LO:    rd_mux = cnt[31:0];
      REG_UP_HI:    rd_mux = shadow;
      REG_SCRATCH0: rd_mux = scratch0;
      REG_SCRATCH1: rd_mux = scratch1;
      REG_CTRL:     rd_mux = {31'd0, en};
      REG_CAPS:     rd_mux = CAPS;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read response; a low-word read freezes the high part for the next read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      shadow        <= '0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (read && (address == REG_UP_LO)) shadow <= cnt_hi;
    end
  end

endmodule

// File: tb/tb_sysid_uptime_slave.sv
// tb_sysid_uptime_slave
// Self-checking bench for sysid_uptime_slave. Two instances share the bus
// address/data lines: dut0 with default parameters and dut4 with PRESCALE=4,
// each with its own strobes. Expected read data is queued when a read is
// issued and compared when readdatavalid comes back.

module tb_sysid_uptime_slave;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read0, write0, read4, write4;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd0, rd4;
  logic        rdv0, rdv4;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb4[$];

  logic [47:0] force_val;

  sysid_uptime_slave dut0 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read0),
    .write         (write0),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (rd0),
    .readdatavalid (rdv0)
  );

  sysid_uptime_slave #(.PRESCALE(4)) dut4 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read4),
    .write         (write4),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (rd4),
    .readdatavalid (rdv4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: pop the oldest pending read and compare data and latency.
  always @(negedge clock) begin
    exp_t e;
    if (rdv0) begin
      if (sb0.size() == 0) check("dut0_spurious_valid", {31'd0, rdv0}, 32'd0);
      else begin
        e = sb0.pop_front();
        check(e.tag, rd0, e.data);
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (rdv4) begin
      if (sb4.size() == 0) check("dut4_spurious_valid", {31'd0, rdv4}, 32'd0);
      else begin
        e = sb4.pop_front();
        check(e.tag, rd4, e.data);
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
      end
    end
  end

  task automatic rd(input bit on4, input logic [2:0] a, input logic [31:0] e, input string tag);
    exp_t x;
    x.tag = tag; x.data = e; x.cyc = cyc;
    address = a;
    if (on4) begin read4 = 1'b1; sb4.push_back(x); end
    else     begin read0 = 1'b1; sb0.push_back(x); end
    @(negedge clock);
    read0 = 1'b0;
    read4 = 1'b0;
  endtask

  task automatic wr(input bit on4, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be;
    if (on4) write4 = 1'b1; else write0 = 1'b1;
    @(negedge clock);
    write0 = 1'b0;
    write4 = 1'b0;
  endtask

  // Simultaneous read and write on dut0 at the same word.
  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic [31:0] e, input string tag);
    exp_t x;
    x.tag = tag; x.data = e; x.cyc = cyc;
    address = a; writedata = d; byteenable = be;
    read0 = 1'b1; write0 = 1'b1;
    sb0.push_back(x);
    @(negedge clock);
    read0 = 1'b0; write0 = 1'b0;
  endtask

  // Preload dut0's counter and read a word in the same cycle.
  task automatic force_rd(input logic [47:0] v, input logic [2:0] a, input logic [31:0] e,
                          input string tag);
    exp_t x;
    x.tag = tag; x.data = e; x.cyc = cyc;
    force_val = v;
    force dut0.cnt = force_val;
    address = a; read0 = 1'b1;
    sb0.push_back(x);
    #1;
    release dut0.cnt;
    @(negedge clock);
    read0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; address = '0; read0 = 0; write0 = 0; read4 = 0; write4 = 0;
    writedata = '0; byteenable = '0; force_val = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rdv0", {31'd0, rdv0}, 32'd0);
    check("reset_rd0",  rd0, 32'd0);
    check("reset_rdv4", {31'd0, rdv4}, 32'd0);
    check("reset_rd4",  rd4, 32'd0);
    reset_n = 1'b1;

    // Prescale 4: ten ticks in forty cycles, freeze, then resume at the same rate.
    repeat (40) @(negedge clock);
    rd(1, 3'd2, 32'd10, "p4_after40");
    wr(1, 3'd6, 32'h0, 4'h1);
    repeat (100) @(negedge clock);
    rd(1, 3'd2, 32'd10, "p4_frozen");
    wr(1, 3'd6, 32'h1, 4'h1);
    repeat (2) @(negedge clock);
    rd(1, 3'd2, 32'd11, "p4_resume1");
    repeat (19) @(negedge clock);
    rd(1, 3'd2, 32'd16, "p4_resume6");
    rd(1, 3'd7, 32'h0000_0330, "p4_caps");

    // Identification words, back to back.
    rd(0, 3'd0, 32'd0, "id");
    rd(0, 3'd1, 32'd1671639825, "timestamp");
    rd(0, 3'd7, 32'h0000_0030, "caps");
    repeat (3) @(negedge clock);
    check("readdata_hold", rd0, 32'h0000_0030);
    check("rdv_single_cycle", {31'd0, rdv0}, 32'd0);
    rd(0, 3'd6, 32'h1, "ctrl_reset");
    rd(0, 3'd4, 32'h0, "scratch0_reset");

    // Scratch byte lanes and read-only words.
    wr(0, 3'd4, 32'hAABB_CCDD, 4'hF);
    wr(0, 3'd4, 32'h1122_3344, 4'h5);
    rd(0, 3'd4, 32'hAA22_CC44, "scratch0_lanes");
    rd(0, 3'd5, 32'h0, "scratch1_untouched");
    wr(0, 3'd5, 32'hDEAD_BEEF, 4'hA);
    rd(0, 3'd5, 32'hDE00_BE00, "scratch1_lanes");
    wr(0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(0, 3'd7, 32'hFFFF_FFFF, 4'hF);
    rd(0, 3'd0, 32'd0, "id_ro");
    rd(0, 3'd7, 32'h0000_0030, "caps_ro");
    rw(3'd4, 32'h5566_7788, 4'hF, 32'hAA22_CC44, "scratch0_rw_old");
    rd(0, 3'd4, 32'h5566_7788, "scratch0_rw_new");

    // Atomic 64-bit read across the 32-bit carry.
    force_rd(48'h0000_FFFF_FFFF, 3'd2, 32'hFFFF_FFFF, "uptime_lo_ffff");
    rd(0, 3'd3, 32'h0, "uptime_hi_carry");
    rd(0, 3'd2, 32'h1, "uptime_lo_after");
    rd(0, 3'd3, 32'h1, "uptime_hi_after");

    // Clear: shadow keeps the pre-clear high part, CLR reads back 0.
    wr(0, 3'd6, 32'h0, 4'h1);
    force_rd(48'h0005_0000_1234, 3'd2, 32'h0000_1234, "lo_pre_clear");
    wr(0, 3'd6, 32'h3, 4'h1);
    rd(0, 3'd3, 32'h5, "hi_after_clear");
    rd(0, 3'd2, 32'h1, "lo_after_clear");
    rd(0, 3'd6, 32'h1, "ctrl_clr_reads0");
    rw(3'd6, 32'h3, 4'h1, 32'h1, "ctrl_rw_old");
    rd(0, 3'd2, 32'h0, "clr_wins_tick");
    rw(3'd6, 32'h0, 4'h1, 32'h1, "ctrl_rw_en_off");
    rd(0, 3'd6, 32'h0, "ctrl_en_off");

    // Reset during an in-flight read response.
    force_rd(48'h0007_0000_0000, 3'd2, 32'h0, "lo_pre_reset");
    rd(0, 3'd3, 32'h7, "hi_pre_reset");
    address = 3'd4; read0 = 1'b1;
    @(posedge clock);
    #1 read0 = 1'b0;
    check("rdv_before_reset", {31'd0, rdv0}, 32'd1);
    check("rd_before_reset", rd0, 32'h5566_7788);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_rdv0", {31'd0, rdv0}, 32'd0);
    check("midreset_rd0",  rd0, 32'd0);
    check("midreset_rd4",  rd4, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rd(0, 3'd3, 32'h0, "hi_after_reset");
    rd(0, 3'd2, 32'h1, "lo_after_reset");
    rd(0, 3'd6, 32'h1, "ctrl_after_reset");
    rd(0, 3'd4, 32'h0, "s0_after_reset");
    rd(0, 3'd5, 32'h0, "s1_after_reset");

    repeat (3) @(negedge clock);
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb4_drained", 32'(sb4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
